// File: rtl/exhaust_pkg.sv
// Shared types and default constants for the exhaust_ctrl_multi range-hood controller.
package exhaust_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_BOOST  = 2'b10,
    ST_RETURN = 2'b11
  } state_e;

  localparam int DEF_NUM_LEVELS = 3;
  localparam int DEF_BOOST_SEC  = 60;
  localparam int DEF_RETURN_SEC = 60;
  localparam int DEF_CNT_W      = 8;

  localparam int LEVEL_OFF = 0;

  // Boost is reported one code above the highest normal level.
  function automatic int boost_level(input int num_levels);
    return num_levels + 1;
  endfunction

endpackage

// File: rtl/sec_countdown.sv
// Loadable seconds down-counter with tick enable, synchronous clear and a
// registered flag that is high while the next tick would reach zero.
module sec_countdown #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             tick_i,
  output logic [CNT_W-1:0] count_o,
  output logic             last_o
);

  logic [CNT_W-1:0] count_d, count_q;
  logic             last_q;

  // NOTE: combinational next-state assigns its default first so no path leaves it unassigned (no latch).
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (tick_i && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      last_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      last_q  <= (count_d == CNT_W'(1));
    end
  end

  assign count_o = count_q;
  assign last_o  = last_q;

endmodule

// File: rtl/exhaust_ctrl_multi.sv
// Range-hood exhaust controller: N fan levels plus timed boost and forced-return delay.
// Optional macro EXHAUST_BOOST_REARM_EN re-arms boost on every entry into IDLE.
module exhaust_ctrl_multi
  import exhaust_pkg::*;
#(
  parameter int NUM_LEVELS = DEF_NUM_LEVELS,
  parameter int BOOST_SEC  = DEF_BOOST_SEC,
  parameter int RETURN_SEC = DEF_RETURN_SEC,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int LVL_W      = $clog2(NUM_LEVELS + 2)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tick_1s,
  input  logic                  power_on,
  input  logic                  menu_key,
  input  logic [NUM_LEVELS-1:0] level_key,
  input  logic                  boost_key,
  output logic [1:0]            state,
  output logic [LVL_W-1:0]      level,
  output logic                  fan_on,
  output logic [CNT_W-1:0]      countdown,
  output logic                  countdown_active,
  output logic                  boost_used
);

`ifdef EXHAUST_BOOST_REARM_EN
  localparam bit REARM = 1'b1;
`else
  localparam bit REARM = 1'b0;
`endif

  localparam logic [LVL_W-1:0] LVL_OFF   = LVL_W'(LEVEL_OFF);
  localparam logic [LVL_W-1:0] LVL_TOP   = LVL_W'(NUM_LEVELS);
  localparam logic [LVL_W-1:0] LVL_BOOST = LVL_W'(boost_level(NUM_LEVELS));

  state_e             state_q, state_d;
  logic [LVL_W-1:0]   level_q, level_d, sel_level;
  logic               fan_on_q, active_q;
  logic               used_q, used_d;
  logic               cnt_clr, cnt_load, cnt_tick, cnt_last;
  logic [CNT_W-1:0]   cnt_load_val, cnt_value;

  // Lowest-index key wins when several level keys arrive together.
  always_comb begin
    sel_level = LVL_OFF;
    for (int i = NUM_LEVELS - 1; i >= 0; i--) begin
      if (level_key[i]) sel_level = LVL_W'(i + 1);
    end
  end

  always_comb begin
    state_d      = state_q;
    level_d      = level_q;
    used_d       = used_q;
    cnt_clr      = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = CNT_W'(BOOST_SEC);

    if (!power_on) begin
      state_d = ST_IDLE;
      level_d = LVL_OFF;
      used_d  = 1'b0;
      cnt_clr = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (|level_key) begin
            state_d = ST_RUN;
            level_d = sel_level;
          end else if (boost_key && !used_q) begin
            state_d  = ST_BOOST;
            level_d  = LVL_BOOST;
            used_d   = 1'b1;
            cnt_load = 1'b1;
          end
        end
        ST_RUN: begin
          if (menu_key) begin
            state_d = ST_IDLE;
            level_d = LVL_OFF;
            if (REARM) used_d = 1'b0;
          end else if (|level_key) begin
            level_d = sel_level;
          end else if (boost_key && !used_q) begin
            state_d  = ST_BOOST;
            level_d  = LVL_BOOST;
            used_d   = 1'b1;
            cnt_load = 1'b1;
          end
        end
        ST_BOOST: begin
          // menu_key beats a coinciding final tick.
          if (menu_key) begin
            state_d      = ST_RETURN;
            level_d      = LVL_OFF;
            cnt_load     = 1'b1;
            cnt_load_val = CNT_W'(RETURN_SEC);
          end else if (tick_1s && cnt_last) begin
            state_d = ST_RUN;
            level_d = LVL_TOP;
            cnt_clr = 1'b1;
          end
        end
        ST_RETURN: begin
          if (tick_1s && cnt_last) begin
            state_d = ST_IDLE;
            cnt_clr = 1'b1;
            if (REARM) used_d = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign cnt_tick = tick_1s && ((state_q == ST_BOOST) || (state_q == ST_RETURN));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      level_q  <= LVL_OFF;
      fan_on_q <= 1'b0;
      active_q <= 1'b0;
      used_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      fan_on_q <= (state_d == ST_RUN) || (state_d == ST_BOOST);
      active_q <= (state_d == ST_BOOST) || (state_d == ST_RETURN);
      used_q   <= used_d;
    end
  end

  sec_countdown #(
    .CNT_W(CNT_W)
  ) u_countdown (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (cnt_clr),
    .load_i    (cnt_load),
    .load_val_i(cnt_load_val),
    .tick_i    (cnt_tick),
    .count_o   (cnt_value),
    .last_o    (cnt_last)
  );

  assign state            = state_q;
  assign level            = level_q;
  assign fan_on           = fan_on_q;
  assign countdown        = cnt_value;
  assign countdown_active = active_q;
  assign boost_used       = used_q;

endmodule

// File: tb/tb_exhaust_ctrl_multi.sv
// Self-checking bench for exhaust_ctrl_multi: vector table, corner-case sequences, random vs model.
module tb_exhaust_ctrl_multi;

  localparam int NL = 3;
  localparam int BS = 5;
  localparam int RS = 60;
  localparam int CW = 8;
  localparam int LW = $clog2(NL + 2);

`ifdef EXHAUST_BOOST_REARM_EN
  localparam bit REARM = 1'b1;
`else
  localparam bit REARM = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tick_1s = 1'b0;
  logic          power_on = 1'b0;
  logic          menu_key = 1'b0;
  logic [NL-1:0] level_key = '0;
  logic          boost_key = 1'b0;
  logic [1:0]    state;
  logic [LW-1:0] level;
  logic          fan_on;
  logic [CW-1:0] countdown;
  logic          countdown_active;
  logic          boost_used;

  exhaust_ctrl_multi #(
    .NUM_LEVELS(NL), .BOOST_SEC(BS), .RETURN_SEC(RS), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick_1s(tick_1s), .power_on(power_on),
    .menu_key(menu_key), .level_key(level_key), .boost_key(boost_key),
    .state(state), .level(level), .fan_on(fan_on), .countdown(countdown),
    .countdown_active(countdown_active), .boost_used(boost_used)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: state codes 0 idle, 1 run, 2 boost, 3 return.
  int m_st, m_lvl, m_cnt;
  bit m_used;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input int st, input int lvl, input int cnt,
                               input int used);
    check({tag, ".state"}, int'(state), st);
    check({tag, ".level"}, int'(level), lvl);
    check({tag, ".fan_on"}, int'(fan_on), (st == 1 || st == 2) ? 1 : 0);
    check({tag, ".countdown"}, int'(countdown), cnt);
    check({tag, ".countdown_active"}, int'(countdown_active), (st >= 2) ? 1 : 0);
    check({tag, ".boost_used"}, int'(boost_used), used);
  endtask

  function automatic int lowest(input logic [NL-1:0] v);
    for (int i = 0; i < NL; i++) if (v[i]) return i + 1;
    return 0;
  endfunction

  task automatic model_reset();
    m_st = 0; m_lvl = 0; m_cnt = 0; m_used = 1'b0;
  endtask

  task automatic model_step(input bit pwr, input bit mk, input logic [NL-1:0] lk,
                            input bit bk, input bit tk);
    if (!pwr) begin
      model_reset();
    end else if (m_st == 0 || m_st == 1) begin
      if (m_st == 1 && mk) begin
        m_st = 0; m_lvl = 0;
        if (REARM) m_used = 1'b0;
      end else if (lk != 0) begin
        m_st = 1; m_lvl = lowest(lk);
      end else if (bk && !m_used) begin
        m_st = 2; m_lvl = NL + 1; m_cnt = BS; m_used = 1'b1;
      end
    end else if (m_st == 2) begin
      if (mk) begin
        m_st = 3; m_lvl = 0; m_cnt = RS;
      end else if (tk) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin m_st = 1; m_lvl = NL; end
      end
    end else begin
      if (tk) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin
          m_st = 0;
          if (REARM) m_used = 1'b0;
        end
      end
    end
  endtask

  // Drive one cycle of inputs, advance DUT and model together, then drop the pulses.
  task automatic apply(input bit pwr, input bit mk, input logic [NL-1:0] lk,
                       input bit bk, input bit tk);
    power_on = pwr; menu_key = mk; level_key = lk; boost_key = bk; tick_1s = tk;
    @(posedge clk);
    model_step(pwr, mk, lk, bk, tk);
    #1;
    menu_key = 1'b0; level_key = '0; boost_key = 1'b0; tick_1s = 1'b0;
  endtask

  task automatic ticks(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      apply(1, 0, '0, 0, 1);
      check_outputs(tag, m_st, m_lvl, m_cnt, int'(m_used));
    end
  endtask

  typedef struct {
    bit            pwr;
    bit            mk;
    logic [NL-1:0] lk;
    bit            bk;
    bit            tk;
    int            st;
    int            lvl;
    int            cnt;
    int            used;
  } vec_t;

  vec_t vecs[14];

  initial begin
    vecs[0]  = '{1, 0, 3'b010, 0, 0, 1, 2, 0, 0};
    vecs[1]  = '{1, 0, 3'b101, 0, 0, 1, 1, 0, 0};
    vecs[2]  = '{1, 0, 3'b000, 0, 1, 1, 1, 0, 0};
    vecs[3]  = '{1, 0, 3'b000, 1, 0, 2, 4, 5, 1};
    vecs[4]  = '{1, 0, 3'b000, 0, 1, 2, 4, 4, 1};
    vecs[5]  = '{1, 0, 3'b001, 1, 1, 2, 4, 3, 1};
    vecs[6]  = '{1, 0, 3'b000, 0, 1, 2, 4, 2, 1};
    vecs[7]  = '{1, 0, 3'b000, 0, 1, 2, 4, 1, 1};
    vecs[8]  = '{1, 0, 3'b000, 0, 1, 1, 3, 0, 1};
    vecs[9]  = '{1, 0, 3'b000, 1, 0, 1, 3, 0, 1};
    vecs[10] = '{1, 1, 3'b000, 0, 0, 0, 0, 0, REARM ? 0 : 1};
    vecs[11] = '{1, 1, 3'b000, 0, 1, 0, 0, 0, REARM ? 0 : 1};
    vecs[12] = '{0, 0, 3'b000, 1, 1, 0, 0, 0, 0};
    vecs[13] = '{1, 0, 3'b000, 1, 0, 2, 4, 5, 1};

    model_reset();
    power_on = 1'b1;
    #12;
    check_outputs("reset", 0, 0, 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      apply(vecs[i].pwr, vecs[i].mk, vecs[i].lk, vecs[i].bk, vecs[i].tk);
      check_outputs($sformatf("vec%0d", i), vecs[i].st, vecs[i].lvl, vecs[i].cnt, vecs[i].used);
    end

    // Boost at countdown 3, menu -> return delay, then keys ignored on the final tick.
    ticks(2, "boost_dec");
    check("boost_at3", int'(countdown), 3);
    apply(1, 1, '0, 0, 0);
    check_outputs("menu_to_return", 3, 0, RS, 1);
    ticks(RS - 1, "return_dec");
    apply(1, 1, 3'b111, 1, 1);
    check_outputs("return_expire", 0, 0, 0, REARM ? 0 : 1);

    // Power cycle re-enables boost; menu and final tick together -> RETURN.
    apply(0, 0, '0, 0, 0);
    apply(1, 0, '0, 1, 0);
    check_outputs("boost_after_pwr", 2, 4, BS, 1);
    ticks(BS - 1, "boost_dec2");
    apply(1, 1, '0, 0, 1);
    check_outputs("menu_beats_tick", 3, 0, RS, 1);

    // Asynchronous reset in the middle of the return countdown.
    ticks(RS - 17, "return_dec2");
    check("return_at17", int'(countdown), 17);
    #2 rst_n = 1'b0;
    #1;
    check_outputs("async_reset", 0, 0, 0, 0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    apply(1, 0, '0, 0, 1);
    check_outputs("post_reset", 0, 0, 0, 0);

    // Boost rearm behaviour after RUN -> IDLE via menu.
    apply(1, 0, '0, 1, 0);
    check_outputs("rearm_boost", 2, 4, BS, 1);
    ticks(BS, "rearm_expire");
    check_outputs("rearm_run", 1, 3, 0, 1);
    apply(1, 1, '0, 0, 0);
    check_outputs("rearm_idle", 0, 0, 0, REARM ? 0 : 1);
    apply(1, 0, '0, 1, 0);
    check_outputs("rearm_retry", REARM ? 2 : 0, REARM ? 4 : 0, REARM ? BS : 0, 1);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 4000; i++) begin
      bit            pwr, mk, bk, tk;
      logic [NL-1:0] lk;
      pwr = ($urandom_range(0, 199) != 0);
      mk  = ($urandom_range(0, 15) == 0);
      lk  = ($urandom_range(0, 7) == 0) ? NL'($urandom) : '0;
      bk  = ($urandom_range(0, 9) == 0);
      tk  = ($urandom_range(0, 2) == 0);
      apply(pwr, mk, lk, bk, tk);
      check_outputs($sformatf("rand%0d", i), m_st, m_lvl, m_cnt, int'(m_used));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/exhaust_ctrl_multi.md
# exhaust_ctrl_multi

Parametrised second-generation range-hood exhaust controller: N normal fan levels plus a time-limited boost level, driven by one-cycle key pulses and a 1 Hz tick. Sits between the key debouncer/edge detector and the fan driver and display blocks, behind the power on/off logic. Adds level-to-boost entry from any running level, configurable timer lengths and a registered status interface.

## Interface
- NUM_LEVELS, 3: normal fan levels, 2..7.
- BOOST_SEC, 60: boost duration in ticks, 1..2^CNT_W-1.
- RETURN_SEC, 60: forced-return delay in ticks, 1..2^CNT_W-1.
- CNT_W, 8: countdown width.
- LVL_W, $clog2(NUM_LEVELS+2): level code width.

- clk  in  1  system clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- tick_1s  in  1  one-cycle pulse once per second.
- power_on  in  1  hood powered; low forces idle.
- menu_key  in  1  one-cycle pulse.
- level_key  in  NUM_LEVELS  one-cycle pulses; bit i selects level i+1.
- boost_key  in  1  one-cycle pulse.
- state  out  2  00 IDLE, 01 RUN, 10 BOOST, 11 RETURN.
- level  out  LVL_W  0 off, 1..NUM_LEVELS normal, NUM_LEVELS+1 boost.
- fan_on  out  1  high in RUN and BOOST.
- countdown  out  CNT_W  remaining ticks in BOOST/RETURN, else 0.
- countdown_active  out  1  high in BOOST and RETURN.
- boost_used  out  1  boost consumed this power cycle.

## Operation
- All outputs registered; reset value: state IDLE, level 0, fan_on 0, countdown 0, countdown_active 0, boost_used 0.
- Several level_key bits in one cycle: lowest index wins.
- IDLE: level_key -> RUN at selected level; else boost_key with boost_used=0 -> BOOST. menu_key ignored.
- RUN: priority menu_key -> IDLE; level_key -> new level, stay RUN; boost_key with boost_used=0 -> BOOST. boost_key with boost_used=1 ignored.
- BOOST entry: countdown <= BOOST_SEC, boost_used <= 1, level <= NUM_LEVELS+1.
- BOOST: tick_1s decrements countdown; tick with countdown==1 -> RUN at level NUM_LEVELS, countdown 0. menu_key -> RETURN, countdown <= RETURN_SEC. Level and boost keys ignored. menu_key and final tick in same cycle: menu_key wins.
- RETURN: fan_on 0, level 0; tick decrements; tick with countdown==1 -> IDLE. All keys ignored.
- power_on low: state IDLE, outputs to reset values, boost_used cleared; overrides every key and tick in that cycle. Held while low.
- countdown never underflows; never loaded with 0.

## Timing
- Key or tick pulse at edge k -> all outputs updated at edge k+1; single-cycle latency, no multi-cycle handshakes.
- BOOST lasts exactly BOOST_SEC ticks from entry; the first tick counted is the first after the entry edge.
- Tick in entry cycle is not counted (load wins over decrement).
- rst_n assertion mid-countdown: immediate clear, asynchronous; release synchronous to clk.

## Configuration
- EXHAUST_BOOST_REARM_EN defined: boost_used also clears on every transition into IDLE (RUN via menu_key, RETURN expiry), so boost is usable again after each idle.
- Undefined: boost_used clears only on reset or power_on low; one boost per power cycle.

## Structure
- Package exhaust_pkg: state enum typedef (IDLE/RUN/BOOST/RETURN, 2-bit codes above), level-code helper constants, default timer constants.
- One sub-module: sec_countdown — loadable CNT_W down-counter with tick enable, synchronous clear, and registered one-tick-to-zero flag; instantiated once, shared by BOOST and RETURN.

## Test plan
- NUM_LEVELS=3: level_key=3'b010 in IDLE -> next cycle state RUN, level 2, fan_on 1; level_key=3'b101 -> level 1.
- BOOST_SEC=5: boost_key from RUN level 1 -> BOOST, level 4, countdown 5; after 5 ticks -> RUN level 3, countdown 0, boost_used 1.
- Second boost_key without macro -> ignored; power_on low for one cycle, power up, boost_key -> BOOST accepted.
- BOOST countdown 3, menu_key -> RETURN, countdown 60, fan_on 0; 60 ticks -> IDLE; menu_key with final tick at countdown 1 -> RETURN.
- rst_n low mid-RETURN countdown 17 -> all outputs zero immediately, IDLE.
- With EXHAUST_BOOST_REARM_EN: boost, expire, menu_key to IDLE -> boost_used 0; boost_key -> BOOST.
